// File: rtl/stopwatch_pkg.sv
// Shared types and default rates for the stopwatch control/datapath/key blocks.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } ctrl_state_t;

  localparam int IN_CLK_HZ = 50_000_000;
  localparam int TICK_HZ   = 100;

  function automatic logic is_running(input logic [1:0] s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Divides the system clock down to a one-cycle registered advance strobe.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Count is held (not cleared) while disabled so a resume finishes the partial period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (zero) begin
        r_cnt <= '0;
      end else if (en) begin
        if (r_cnt == CW'(DIV - 1)) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: Start/Stop and Lap/Reset keys drive the
// time-counter tick, clear strobe, lap display hold and a lap counter.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = stopwatch_pkg::IN_CLK_HZ,
  parameter int TICK_HZ = stopwatch_pkg::TICK_HZ,
  parameter int LAP_MAX = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_ss,
  input  logic                         key_lr,
  output logic                         tick_o,
  output logic                         clr_o,
  output logic                         run_o,
  output logic                         hold_o,
  output logic [$clog2(LAP_MAX+1)-1:0] lap_cnt_o,
  output logic [1:0]                   state_o
);

  import stopwatch_pkg::*;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int LW  = $clog2(LAP_MAX + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_LAP   = LAP;
  localparam logic [1:0] ST_PAUSE = PAUSE;

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_cfg
      $error("stopwatch_ctrl: CLK_HZ must be a multiple of TICK_HZ with DIV >= 2");
    end
  endgenerate

  logic [1:0]    r_state;
  logic          r_run;
  logic          r_hold;
  logic          r_clr;
  logic [LW-1:0] r_lap;

  logic [1:0]    w_state_nxt;
  logic          w_run_nxt;
  logic          w_lap_inc;
  logic          w_clr;
  logic          w_zero;
  logic          w_en;
  logic          w_tick;

  // key_ss is tested first in every state so it wins over a coincident key_lr.
  always_comb begin
    w_state_nxt = r_state;
    w_lap_inc   = 1'b0;
    w_clr       = 1'b0;
    w_zero      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (key_ss) begin
          w_state_nxt = ST_RUN;
          w_zero      = 1'b1;
        end
      end
      ST_RUN: begin
        if (key_ss) begin
          w_state_nxt = ST_PAUSE;
        end else if (key_lr) begin
          w_state_nxt = ST_LAP;
          w_lap_inc   = 1'b1;
        end
      end
      ST_LAP: begin
        if (key_ss)      w_state_nxt = ST_PAUSE;
        else if (key_lr) w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (key_ss) begin
          w_state_nxt = ST_RUN;
        end else if (key_lr) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
          w_zero      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_run_nxt = is_running(w_state_nxt);

  // Only edges with timing active on both sides advance the prescaler, so the
  // stop and resume edges themselves leave the partial period untouched.
  assign w_en = r_run & w_run_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
      r_hold  <= 1'b0;
      r_clr   <= 1'b0;
      r_lap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_hold  <= (w_state_nxt == ST_LAP);
      r_clr   <= w_clr;
      if (w_clr) begin
        r_lap <= '0;
      end else if (w_lap_inc && (r_lap != LW'(LAP_MAX))) begin
        r_lap <= r_lap + LW'(1);
      end
    end
  end

  tick_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_en),
    .zero  (w_zero),
    .tick  (w_tick)
  );

  assign tick_o    = w_tick;
  assign clr_o     = r_clr;
  assign run_o     = r_run;
  assign hold_o    = r_hold;
  assign lap_cnt_o = r_lap;
  assign state_o   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at DIV=10, LAP_MAX=3; expected tick cycles are queued
// as keys are driven and matched against tick_o by a monitor.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int LAP_MAX = 3;
  localparam int LW      = $clog2(LAP_MAX + 1);

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          key_ss = 1'b0;
  logic          key_lr = 1'b0;
  logic          tick_o;
  logic          clr_o;
  logic          run_o;
  logic          hold_o;
  logic [LW-1:0] lap_cnt_o;
  logic [1:0]    state_o;

  stopwatch_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .LAP_MAX (LAP_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_ss    (key_ss),
    .key_lr    (key_lr),
    .tick_o    (tick_o),
    .clr_o     (clr_o),
    .run_o     (run_o),
    .hold_o    (hold_o),
    .lap_cnt_o (lap_cnt_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int base     = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int mon_e;

  // {state_o, run_o, hold_o, clr_o, lap_cnt_o}
  logic [6:0] obs;
  assign obs = {state_o, run_o, hold_o, clr_o, lap_cnt_o};

  always @(posedge clk) cyc <= cyc + 1;

  // Tick scoreboard: every tick must match the oldest queued cycle; a queued
  // cycle that passes without a tick is reported as missed.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      n_checks++;
      n_fail++;
      mon_e = exp_q.pop_front();
      $display("FAIL tick_missed: no tick_o at cycle %0d, required one", mon_e - base);
    end
    if (tick_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tick_unexpected: tick_o=1 at cycle %0d, required 0", cyc - base);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          n_fail++;
          $display("FAIL tick_cycle: tick_o at cycle %0d, required cycle %0d", cyc - base, mon_e - base);
        end
      end
    end
    if (tick_o && clr_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_clr_overlap: tick_o=1 clr_o=1 at cycle %0d, required not both", cyc - base);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic go_to(input int rel);
    int tgt;
    tgt = base + rel;
    if (cyc > tgt) begin
      n_checks++;
      n_fail++;
      $display("FAIL sequencing: at cycle %0d, required <= %0d", cyc - base, rel);
    end
    while (cyc < tgt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic ss, input logic lr, input int rel);
    go_to(rel);
    key_ss = ss;
    key_lr = lr;
    @(posedge clk);
    #1;
    key_ss = 1'b0;
    key_lr = 1'b0;
  endtask

  task automatic do_reset();
    key_ss = 1'b0;
    key_lr = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  task automatic end_check(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_ticks_pending: %0d expected ticks left, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({obs, tick_o} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: outputs=%b, required %b", {obs, tick_o}, 8'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({obs, tick_o} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%b, required %b", {obs, tick_o}, 8'b0);
    end
  endtask

  task automatic test_start();
    do_reset();
    exp_q.push_back(base + 16);
    exp_q.push_back(base + 26);
    exp_q.push_back(base + 36);
    pulse(1'b1, 1'b0, 5);
    n_checks++;
    if (obs !== 7'b01_1_0_0_00) begin
      n_fail++;
      $display("FAIL start_run: st/run/hold/clr/lap=%b, required %b", obs, 7'b01_1_0_0_00);
    end
    go_to(39);
    end_check("start");
  endtask

  task automatic test_lap();
    do_reset();
    exp_q.push_back(base + 11);
    exp_q.push_back(base + 21);
    exp_q.push_back(base + 31);
    exp_q.push_back(base + 41);
    pulse(1'b1, 1'b0, 0);
    pulse(1'b0, 1'b1, 13);
    n_checks++;
    if (obs !== 7'b10_1_1_0_01) begin
      n_fail++;
      $display("FAIL lap_first: st/run/hold/clr/lap=%b, required %b", obs, 7'b10_1_1_0_01);
    end
    pulse(1'b0, 1'b1, 17);
    n_checks++;
    if (obs !== 7'b01_1_0_0_01) begin
      n_fail++;
      $display("FAIL lap_release: st/run/hold/clr/lap=%b, required %b", obs, 7'b01_1_0_0_01);
    end
    pulse(1'b0, 1'b1, 19);
    pulse(1'b0, 1'b1, 23);
    pulse(1'b0, 1'b1, 25);
    n_checks++;
    if (obs !== 7'b10_1_1_0_11) begin
      n_fail++;
      $display("FAIL lap_third: st/run/hold/clr/lap=%b, required %b", obs, 7'b10_1_1_0_11);
    end
    pulse(1'b0, 1'b1, 27);
    pulse(1'b0, 1'b1, 29);
    n_checks++;
    if (obs !== 7'b10_1_1_0_11) begin
      n_fail++;
      $display("FAIL lap_saturate: st/run/hold/clr/lap=%b, required %b", obs, 7'b10_1_1_0_11);
    end
    go_to(44);
    end_check("lap");
  endtask

  task automatic test_pause_resume();
    do_reset();
    exp_q.push_back(base + 11);
    pulse(1'b1, 1'b0, 0);
    pulse(1'b1, 1'b0, 14);
    n_checks++;
    if (obs !== 7'b11_0_0_0_00) begin
      n_fail++;
      $display("FAIL pause_enter: st/run/hold/clr/lap=%b, required %b", obs, 7'b11_0_0_0_00);
    end
    exp_q.push_back(base + 48);
    exp_q.push_back(base + 58);
    pulse(1'b1, 1'b0, 40);
    n_checks++;
    if (obs !== 7'b01_1_0_0_00) begin
      n_fail++;
      $display("FAIL pause_resume: st/run/hold/clr/lap=%b, required %b", obs, 7'b01_1_0_0_00);
    end
    go_to(60);
    end_check("pause");
  endtask

  task automatic test_clear();
    do_reset();
    exp_q.push_back(base + 11);
    pulse(1'b1, 1'b0, 0);
    pulse(1'b0, 1'b1, 13);
    pulse(1'b1, 1'b0, 15);
    n_checks++;
    if (obs !== 7'b11_0_0_0_01) begin
      n_fail++;
      $display("FAIL lap_to_pause: st/run/hold/clr/lap=%b, required %b", obs, 7'b11_0_0_0_01);
    end
    pulse(1'b0, 1'b1, 20);
    n_checks++;
    if (obs !== 7'b00_0_0_1_00) begin
      n_fail++;
      $display("FAIL clear_strobe: st/run/hold/clr/lap=%b, required %b", obs, 7'b00_0_0_1_00);
    end
    go_to(22);
    n_checks++;
    if (obs !== 7'b00_0_0_0_00) begin
      n_fail++;
      $display("FAIL clear_one_cycle: st/run/hold/clr/lap=%b, required %b", obs, 7'b00_0_0_0_00);
    end
    exp_q.push_back(base + 36);
    pulse(1'b1, 1'b0, 25);
    go_to(37);
    end_check("clear");
  endtask

  task automatic test_simultaneous();
    do_reset();
    exp_q.push_back(base + 11);
    pulse(1'b1, 1'b0, 0);
    pulse(1'b0, 1'b1, 13);
    pulse(1'b0, 1'b1, 15);
    pulse(1'b1, 1'b1, 17);
    n_checks++;
    if (obs !== 7'b11_0_0_0_01) begin
      n_fail++;
      $display("FAIL simul_keys: st/run/hold/clr/lap=%b, required %b", obs, 7'b11_0_0_0_01);
    end
    go_to(30);
    end_check("simul");
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back(base + 11);
    pulse(1'b1, 1'b0, 0);
    pulse(1'b0, 1'b1, 13);
    go_to(15);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({obs, tick_o} !== 8'b0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%b, required %b", {obs, tick_o}, 8'b0);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    pulse(1'b0, 1'b1, 2);
    n_checks++;
    if (obs !== 7'b00_0_0_0_00) begin
      n_fail++;
      $display("FAIL idle_ignores_lr: st/run/hold/clr/lap=%b, required %b", obs, 7'b00_0_0_0_00);
    end
    go_to(20);
    end_check("async");
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_resume();
    test_clear();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
